// File: rtl/matmul_push_unit_if.sv
// Push-unit bus: scheduler request and register-lane reads in, skewed systolic edge feed out.
interface matmul_push_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    start_push;
  logic [8*DATA_WIDTH-1:0] reg_read_data;
  logic [1:0]              reg_read_sel;
  logic [4*DATA_WIDTH-1:0] a_edge;
  logic [4*DATA_WIDTH-1:0] b_edge;
  logic                    edge_valid;
  logic                    clear_acc;
  logic                    busy;
  logic                    matmul_done;

  modport master (
    output start_push, reg_read_data,
    input  reg_read_sel, a_edge, b_edge, edge_valid, clear_acc, busy, matmul_done
  );

  modport slave (
    input  start_push, reg_read_data,
    output reg_read_sel, a_edge, b_edge, edge_valid, clear_acc, busy, matmul_done
  );
endinterface

// File: rtl/matmul_push_unit.sv
// Loads 4x4 operands A and B from the 8 register lanes, then streams them diagonally skewed
// into the systolic array (A on the left edge, B on top) and flags done after the array drains.
module matmul_push_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  matmul_push_unit_if.slave bus
);
  localparam int N           = 4;
  localparam int FEED_CYCLES = 2 * N - 1;
  localparam int CNT_MAX     = (DRAIN_CYCLES > FEED_CYCLES) ? DRAIN_CYCLES : FEED_CYCLES;
  localparam int CW          = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] a_store_reg [N][N];
  logic [DATA_WIDTH-1:0] b_store_reg [N][N];
  logic [1:0]            load_idx;

  assign load_idx = cnt_reg[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    bus.reg_read_sel = 2'd0;
    bus.clear_acc    = 1'b0;
    bus.edge_valid   = 1'b0;
    bus.busy         = 1'b0;
    bus.matmul_done  = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        bus.matmul_done = (state_reg == DONE);
        if (bus.start_push) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        bus.busy         = 1'b1;
        bus.reg_read_sel = load_idx;
        // The last quarter read coincides with the accumulator clear so FEED starts on zeroed sums.
        bus.clear_acc    = (load_idx == 2'd3);
        if (cnt_reg == CW'(N - 1)) begin
          state_next = FEED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      FEED: begin
        bus.busy       = 1'b1;
        bus.edge_valid = 1'b1;
        if (cnt_reg == CW'(FEED_CYCLES - 1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (cnt_reg == CW'(DRAIN_CYCLES - 1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Quarter q holds rows 2q%4 (lanes 0-3) and 2q%4+1 (lanes 4-7) of A for q<2, of B otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_store_reg[r][c] <= '0;
          b_store_reg[r][c] <= '0;
        end
      end
    end else if (state_reg == LOAD) begin
      for (int c = 0; c < N; c++) begin
        if (!load_idx[1]) begin
          a_store_reg[{load_idx[0], 1'b0}][c] <= bus.reg_read_data[c*DATA_WIDTH +: DATA_WIDTH];
          a_store_reg[{load_idx[0], 1'b1}][c] <= bus.reg_read_data[(c+N)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          b_store_reg[{load_idx[0], 1'b0}][c] <= bus.reg_read_data[c*DATA_WIDTH +: DATA_WIDTH];
          b_store_reg[{load_idx[0], 1'b1}][c] <= bus.reg_read_data[(c+N)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Row/column gi sees element k-gi of its diagonal; outside 0..N-1 it is padded with zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    logic [CW-1:0] diag;
    logic          hit;
    assign diag = cnt_reg - CW'(gi);
    assign hit  = (state_reg == FEED) && (cnt_reg >= CW'(gi)) && (diag < CW'(N));
    assign bus.a_edge[gi*DATA_WIDTH +: DATA_WIDTH] = hit ? a_store_reg[gi][diag[1:0]] : '0;
    assign bus.b_edge[gi*DATA_WIDTH +: DATA_WIDTH] = hit ? b_store_reg[diag[1:0]][gi] : '0;
  end
endmodule

// File: tb/tb_matmul_push_unit.sv
// Drives two builds (drain 3 and drain 5) from a register-file model and checks every cycle against a timeline model.
module tb_matmul_push_unit;
  localparam int DW = 16;

  typedef struct packed {
    logic [4*DW-1:0] a;
    logic [4*DW-1:0] b;
    logic            ev;
    logic            ca;
    logic            busy;
    logic            done;
    logic [1:0]      sel;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_push = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0]   rf_a [4][4];
  logic [DW-1:0]   rf_b [4][4];
  logic [DW-1:0]   m_a  [4][4];
  logic [DW-1:0]   m_b  [4][4];
  logic [8*DW-1:0] quarter [4];

  always #5 clk = ~clk;

  matmul_push_unit_if #(.DATA_WIDTH(DW)) bus3 ();
  matmul_push_unit_if #(.DATA_WIDTH(DW)) bus5 ();

  matmul_push_unit #(.DATA_WIDTH(DW), .DRAIN_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );
  matmul_push_unit #(.DATA_WIDTH(DW), .DRAIN_CYCLES(5)) dut5 (
    .clk(clk), .reset(reset), .bus(bus5.slave)
  );

  // Register file: quarter q packs two matrix rows onto the 8 lanes.
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      quarter[q] = '0;
      for (int t = 0; t < 8; t++) begin
        if (q < 2) quarter[q][t*DW +: DW] = rf_a[(2*q)%4 + t/4][t%4];
        else       quarter[q][t*DW +: DW] = rf_b[(2*q)%4 + t/4][t%4];
      end
    end
  end

  assign bus3.start_push    = start_push;
  assign bus5.start_push    = start_push;
  assign bus3.reg_read_data = quarter[bus3.reg_read_sel];
  assign bus5.reg_read_data = quarter[bus5.reg_read_sel];

  obs_t obs3, obs5;
  assign obs3 = {bus3.a_edge, bus3.b_edge, bus3.edge_valid, bus3.clear_acc, bus3.busy,
                 bus3.matmul_done, bus3.reg_read_sel};
  assign obs5 = {bus5.a_edge, bus5.b_edge, bus5.edge_valid, bus5.clear_acc, bus5.busy,
                 bus5.matmul_done, bus5.reg_read_sel};

  // Expected outputs in cycle c after the accepted start edge E0 (cycle c ends at edge Ec).
  function automatic obs_t model(input int c, input int d);
    obs_t e;
    int   k;
    e = '0;
    if (c >= 1 && c <= 4) begin
      e.busy = 1'b1;
      e.sel  = 2'(c - 1);
      e.ca   = (c == 4);
    end else if (c >= 5 && c <= 11) begin
      k      = c - 5;
      e.busy = 1'b1;
      e.ev   = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (k - i >= 0 && k - i < 4) begin
          e.a[i*DW +: DW] = m_a[i][k-i];
          e.b[i*DW +: DW] = m_b[k-i][i];
        end
      end
    end else if (c >= 12 && c <= 11 + d) begin
      e.busy = 1'b1;
    end else if (c >= 12 + d) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic fill_rf(input int mode);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (mode == 1) begin
          rf_a[i][j] = 16'd5;
          rf_b[i][j] = 16'd7;
        end else if (mode == 2) begin
          rf_a[i][j] = 16'(4*i + j + 1);
          rf_b[i][j] = 16'(16 + 4*i + j + 1);
        end else begin
          rf_a[i][j] = 16'($urandom);
          rf_b[i][j] = 16'($urandom);
        end
      end
    end
  endtask

  // Raises start_push so the next posedge is E0; the model adopts the register-file contents.
  task automatic launch();
    @(negedge clk);
    m_a = rf_a;
    m_b = rf_b;
    start_push = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_push = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs3 !== obs_t'(0)) begin errors++; $display("FAIL reset_d3: got %h expected 0", obs3); end
    checks++;
    if (obs5 !== obs_t'(0)) begin errors++; $display("FAIL reset_d5: got %h expected 0", obs5); end
    reset = 1'b1;
    start_push = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs3 !== obs_t'(0)) begin errors++; $display("FAIL idle_d3: got %h expected 0", obs3); end
    checks++;
    if (obs5 !== obs_t'(0)) begin errors++; $display("FAIL idle_d5: got %h expected 0", obs5); end
  endtask

  task automatic test_directed();
    fill_rf(2);
    launch();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_push = 1'b0;
      checks++;
      if (obs3 !== model(c, 3)) begin
        errors++; $display("FAIL directed_d3 cyc %0d: got %h expected %h", c, obs3, model(c, 3));
      end
      checks++;
      if (obs5 !== model(c, 5)) begin
        errors++; $display("FAIL directed_d5 cyc %0d: got %h expected %h", c, obs5, model(c, 5));
      end
      if (c == 5) begin
        checks++;
        if (obs3.a !== 64'h0000_0000_0000_0001 || obs3.b !== 64'h0000_0000_0000_0011) begin
          errors++; $display("FAIL k0_edges: got a=%h b=%h expected a=1 b=11", obs3.a, obs3.b);
        end
      end
      if (c == 8) begin
        checks++;
        if (obs3.a[63:48] !== 16'd13 || obs3.b[15:0] !== 16'd29) begin
          errors++; $display("FAIL k3_edges: got a3=%0d b0=%0d expected 13 29", obs3.a[63:48], obs3.b[15:0]);
        end
      end
      if (c == 11) begin
        checks++;
        if (obs3.a !== {16'd16, 48'h0} || obs3.b !== {16'd32, 48'h0}) begin
          errors++; $display("FAIL k6_edges: got a=%h b=%h", obs3.a, obs3.b);
        end
      end
      if (c == 14 || c == 15) begin
        checks++;
        if (obs3.done !== (c == 15)) begin
          errors++; $display("FAIL done_e14 cyc %0d: got %b expected %b", c, obs3.done, (c == 15));
        end
      end
      if (c == 16 || c == 17) begin
        checks++;
        if (obs5.done !== (c == 17)) begin
          errors++; $display("FAIL done_e16 cyc %0d: got %b expected %b", c, obs5.done, (c == 17));
        end
      end
    end
  endtask

  task automatic test_random_ops();
    int ev_count;
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        checks++;
        if (obs3 !== model(99, 3) || obs5 !== model(99, 5)) begin
          errors++; $display("FAIL done_hold op %0d: got %h / %h", n, obs3, obs5);
        end
      end
      fill_rf(n == 0 ? 1 : 0);
      launch();
      ev_count = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        // Requests while busy must be ignored; keep the line quiet once either build can accept.
        start_push = (c <= 13) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (c == 5) fill_rf(0);
        if (obs3.ev) ev_count++;
        checks++;
        if (obs3 !== model(c, 3)) begin
          errors++; $display("FAIL random_d3 op %0d cyc %0d: got %h expected %h", n, c, obs3, model(c, 3));
        end
        checks++;
        if (obs5 !== model(c, 5)) begin
          errors++; $display("FAIL random_d5 op %0d cyc %0d: got %h expected %h", n, c, obs5, model(c, 5));
        end
      end
      checks++;
      if (ev_count !== 7) begin
        errors++; $display("FAIL edge_valid_len op %0d: got %0d expected 7", n, ev_count);
      end
    end
  endtask

  task automatic test_hold_start();
    fill_rf(0);
    launch();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (obs3 !== model((c - 1) % 15 + 1, 3)) begin
        errors++; $display("FAIL hold_d3 cyc %0d: got %h expected %h", c, obs3, model((c - 1) % 15 + 1, 3));
      end
      checks++;
      if (obs5 !== model((c - 1) % 17 + 1, 5)) begin
        errors++; $display("FAIL hold_d5 cyc %0d: got %h expected %h", c, obs5, model((c - 1) % 17 + 1, 5));
      end
    end
    start_push = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (obs3 !== obs_t'(0) || obs5 !== obs_t'(0)) begin
      errors++; $display("FAIL hold_reset: got %h / %h expected 0", obs3, obs5);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    fill_rf(0);
    launch();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start_push = 1'b0;
      checks++;
      if (obs3 !== model(c, 3)) begin
        errors++; $display("FAIL premid_d3 cyc %0d: got %h expected %h", c, obs3, model(c, 3));
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs3 !== obs_t'(0)) begin errors++; $display("FAIL midreset_d3: got %h expected 0", obs3); end
    checks++;
    if (obs5 !== obs_t'(0)) begin errors++; $display("FAIL midreset_d5: got %h expected 0", obs5); end
    @(negedge clk);
    reset = 1'b1;
    fill_rf(0);
    @(negedge clk);
    checks++;
    if (obs3 !== obs_t'(0) || obs5 !== obs_t'(0)) begin
      errors++; $display("FAIL postreset_idle: got %h / %h expected 0", obs3, obs5);
    end
    launch();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_push = 1'b0;
      checks++;
      if (obs3 !== model(c, 3)) begin
        errors++; $display("FAIL rerun_d3 cyc %0d: got %h expected %h", c, obs3, model(c, 3));
      end
      checks++;
      if (obs5 !== model(c, 5)) begin
        errors++; $display("FAIL rerun_d5 cyc %0d: got %h expected %h", c, obs5, model(c, 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      fill_rf(0);
      launch();
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        start_push = 1'b0;
        checks++;
        if (obs3 !== model(c, 3)) begin
          errors++; $display("FAIL b2b_d3 op %0d cyc %0d: got %h expected %h", n, c, obs3, model(c, 3));
        end
        checks++;
        if (obs5 !== model(c, 5)) begin
          errors++; $display("FAIL b2b_d5 op %0d cyc %0d: got %h expected %h", n, c, obs5, model(c, 5));
        end
      end
    end
  endtask

  initial begin
    fill_rf(0);
    test_reset();
    test_directed();
    test_random_ops();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
